// File: rtl/pmesh_l2_fwdack_unit.sv
// rtl/pmesh_l2_fwdack_unit.sv - PMESH L2 forward-ack handler; L2_FWDACK_OWNER_CHECK_EN adds owner match on hit
module pmesh_l2_fwdack_unit #(
  parameter int         NUM_ENTRIES    = 4,
  parameter int         TAG_W          = 26,
  parameter int         DATA_W         = 64,
  parameter int         SRC_W          = 6,
  parameter logic [7:0] STORE_FWDACK_T = 8'h16,
  parameter logic [7:0] LOAD_FWDACK_T  = 8'h15,
  parameter logic [7:0] ACK_T          = 8'h20,
  parameter logic [7:0] NACK_T         = 8'h21
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           msg3_valid,
  output logic                           msg3_ready,
  input  logic [7:0]                     msg3_type,
  input  logic [TAG_W-1:0]               msg3_tag,
  input  logic [SRC_W-1:0]               msg3_source,
  input  logic [DATA_W-1:0]              msg3_data,
  output logic                           msg2_valid,
  input  logic                           msg2_ready,
  output logic [7:0]                     msg2_type,
  output logic [TAG_W-1:0]               msg2_tag,
  output logic [SRC_W-1:0]               msg2_dest,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [$clog2(NUM_ENTRIES)-1:0] alloc_idx,
  input  logic [TAG_W-1:0]               alloc_tag,
  input  logic [SRC_W-1:0]               alloc_owner,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_idx,
  output logic [TAG_W-1:0]               rd_tag,
  output logic [1:0]                     rd_vd,
  output logic [1:0]                     rd_state,
  output logic [DATA_W-1:0]              rd_data,
  output logic [SRC_W-1:0]               rd_owner,
  output logic [1:0]                     cur_msg_state,
  output logic [7:0]                     cycles_since_ack
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [7:0]        req_type_q, req_type_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [SRC_W-1:0]  req_src_q, req_src_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
  logic              msg2_valid_q, msg2_valid_d;
  logic [7:0]        msg2_type_q, msg2_type_d;
  logic [TAG_W-1:0]  msg2_tag_q, msg2_tag_d;
  logic [SRC_W-1:0]  msg2_dest_q, msg2_dest_d;
  logic [1:0]        cms_q, cms_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [TAG_W-1:0]  tag_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]  tag_d   [NUM_ENTRIES];
  logic [1:0]        vd_q    [NUM_ENTRIES];
  logic [1:0]        vd_d    [NUM_ENTRIES];
  logic [1:0]        st_q    [NUM_ENTRIES];
  logic [1:0]        st_d    [NUM_ENTRIES];
  logic [DATA_W-1:0] data_q  [NUM_ENTRIES];
  logic [DATA_W-1:0] data_d  [NUM_ENTRIES];
  logic [SRC_W-1:0]  owner_q [NUM_ENTRIES];
  logic [SRC_W-1:0]  owner_d [NUM_ENTRIES];

  logic                   is_fwdack;
  logic                   accept;
  logic [NUM_ENTRIES-1:0] match;
  logic                   lkp_hit;
  logic [IDX_W-1:0]       lkp_idx;

  assign is_fwdack   = (msg3_type == STORE_FWDACK_T) || (msg3_type == LOAD_FWDACK_T);
  assign msg3_ready  = (fsm_q == S_IDLE);
  assign accept      = msg3_ready && msg3_valid && is_fwdack;
  assign alloc_ready = (fsm_q != S_UPDATE);

  assign msg2_valid       = msg2_valid_q;
  assign msg2_type        = msg2_type_q;
  assign msg2_tag         = msg2_tag_q;
  assign msg2_dest        = msg2_dest_q;
  assign cur_msg_state    = cms_q;
  assign cycles_since_ack = cnt_q;

  assign rd_tag   = tag_q[rd_idx];
  assign rd_vd    = vd_q[rd_idx];
  assign rd_state = st_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
  assign rd_owner = owner_q[rd_idx];

  // Pending-forward match per entry against the latched request; lowest index wins
  always_comb begin
    lkp_hit = 1'b0;
    lkp_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = (st_q[i] == 2'd2) && (tag_q[i] == req_tag_q);
`ifdef L2_FWDACK_OWNER_CHECK_EN
      match[i] = match[i] && (owner_q[i] == req_src_q);
`endif
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        lkp_hit = 1'b1;
        lkp_idx = IDX_W'(i);
      end
    end
  end

  // Next-state for the message FSM, entry array, response and ack counter
  always_comb begin
    fsm_d        = fsm_q;
    req_type_d   = req_type_q;
    req_tag_d    = req_tag_q;
    req_src_d    = req_src_q;
    req_data_d   = req_data_q;
    hit_d        = hit_q;
    hit_idx_d    = hit_idx_q;
    msg2_valid_d = msg2_valid_q;
    msg2_type_d  = msg2_type_q;
    msg2_tag_d   = msg2_tag_q;
    msg2_dest_d  = msg2_dest_q;
    cms_d        = cms_q;
    tag_d        = tag_q;
    vd_d         = vd_q;
    st_d         = st_q;
    data_d       = data_q;
    owner_d      = owner_q;

    case (fsm_q)
      S_IDLE: begin
        // Non-fwdack types are consumed here without any effect
        if (accept) begin
          req_type_d = msg3_type;
          req_tag_d  = msg3_tag;
          req_src_d  = msg3_source;
          req_data_d = msg3_data;
          cms_d      = 2'd1;
          fsm_d      = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d     = lkp_hit;
        hit_idx_d = lkp_idx;
        fsm_d     = S_UPDATE;
      end
      S_UPDATE: begin
        if (hit_q) begin
          st_d[hit_idx_q]   = (req_type_q == STORE_FWDACK_T) ? 2'd0 : 2'd1;
          vd_d[hit_idx_q]   = 2'd3;
          data_d[hit_idx_q] = req_data_q;
`ifdef L2_FWDACK_OWNER_CHECK_EN
          owner_d[hit_idx_q] = '0;
`endif
          cms_d       = 2'd2;
          msg2_type_d = ACK_T;
        end else begin
          cms_d       = 2'd3;
          msg2_type_d = NACK_T;
        end
        msg2_tag_d   = req_tag_q;
        msg2_dest_d  = req_src_q;
        msg2_valid_d = 1'b1;
        fsm_d        = S_RESP;
      end
      default: begin
        if (msg2_ready) begin
          msg2_valid_d = 1'b0;
          fsm_d        = S_IDLE;
        end
      end
    endcase

    // Allocation is blocked during UPDATE, so it never collides with the fwdack write
    if (alloc_valid && alloc_ready) begin
      tag_d[alloc_idx]   = alloc_tag;
      owner_d[alloc_idx] = alloc_owner;
      st_d[alloc_idx]    = 2'd2;
      vd_d[alloc_idx]    = 2'd0;
    end

    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = 8'd1;
    end else if ((cnt_q != 8'd0) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers with asynchronous reset; reset drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      req_type_q   <= '0;
      req_tag_q    <= '0;
      req_src_q    <= '0;
      req_data_q   <= '0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      msg2_valid_q <= 1'b0;
      msg2_type_q  <= '0;
      msg2_tag_q   <= '0;
      msg2_dest_q  <= '0;
      cms_q        <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i]   <= '0;
        vd_q[i]    <= '0;
        st_q[i]    <= '0;
        data_q[i]  <= '0;
        owner_q[i] <= '0;
      end
    end else begin
      fsm_q        <= fsm_d;
      req_type_q   <= req_type_d;
      req_tag_q    <= req_tag_d;
      req_src_q    <= req_src_d;
      req_data_q   <= req_data_d;
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      msg2_valid_q <= msg2_valid_d;
      msg2_type_q  <= msg2_type_d;
      msg2_tag_q   <= msg2_tag_d;
      msg2_dest_q  <= msg2_dest_d;
      cms_q        <= cms_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      vd_q         <= vd_d;
      st_q         <= st_d;
      data_q       <= data_d;
      owner_q      <= owner_d;
    end
  end

endmodule
